masked_subnib_seq: RTL and testbench

- Two-share (DOM) sequencer that drives the masked 4-bit SBox one nibble per cycle across a full 16-bit S-AES state.
- Sits directly upstream of SBox: latches the shared state, issues nibbles, and forwards fresh randomness every cycle.
- Collects the 2-cycle-latency shares back, optionally applies ShiftRows, and presents the masked SubNibbles(+ShiftRows) state to the round logic.

---
 rtl/masked_subnib_seq_pkg.sv | 55 +++++
 rtl/masked_subnib_seq_sbox.sv | 62 ++++++
 rtl/masked_subnib_seq.sv | 123 ++++++++++++
 tb/tb_masked_subnib_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/masked_subnib_seq_pkg.sv
// Shared constants, state encoding and GF(2^4) helpers for the masked S-AES
// SubNibbles sequencer and its two-share S-box.
package masked_subnib_seq_pkg;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned STATE_W  = 16;
  localparam int unsigned RAND_W   = 18;
  localparam int unsigned SBOX_LAT = 2;
  localparam int unsigned LAST_CNT = 5;
  localparam int unsigned NUM_NIB  = STATE_W / NIB_W;

  // rand_in = {Az0,Bz0,Az1,Bz1,Az2,Bz2,Z0,Z1,Z2}, 2 bits per field
  localparam int unsigned RAND_AZ0 = 16;
  localparam int unsigned RAND_BZ0 = 14;
  localparam int unsigned RAND_AZ1 = 12;
  localparam int unsigned RAND_BZ1 = 10;
  localparam int unsigned RAND_AZ2 = 8;
  localparam int unsigned RAND_BZ2 = 6;
  localparam int unsigned RAND_Z0  = 4;
  localparam int unsigned RAND_Z1  = 2;
  localparam int unsigned RAND_Z2  = 0;

  typedef enum logic {IDLE, RUN} state_e;

  // Nibble n0 is the most significant nibble of the state.
  function automatic int unsigned nib_lo(input logic [1:0] idx);
    return STATE_W - NIB_W - NIB_W * int'(idx);
  endfunction

  // GF(2^4) product modulo x^4 + x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] s;
    p = '0;
    s = a;
    for (int unsigned i = 0; i < NIB_W; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] a);
    return gf_mul(a, a);
  endfunction

  // Linear part of the S-AES affine map; the 0x9 constant goes on share A only.
  function automatic logic [3:0] saes_lin(input logic [3:0] v);
    return {v[0] ^ v[1] ^ v[3],
            v[0] ^ v[2] ^ v[3],
            v[1] ^ v[2] ^ v[3],
            v[0] ^ v[1] ^ v[2]};
  endfunction

endpackage

// File: rtl/masked_subnib_seq_sbox.sv
// Two-share DOM S-AES S-box, 2-cycle latency: inverse computed as (x^3)^4 * x^2
// with one DOM multiplier per pipeline stage, then the affine map per share.
module masked_subnib_seq_sbox
  import masked_subnib_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NIB_W-1:0]  a_i,
  input  logic [NIB_W-1:0]  b_i,
  input  logic [RAND_W-1:0] rand_i,
  output logic [NIB_W-1:0]  a_o,
  output logic [NIB_W-1:0]  b_o
);

  logic [3:0] r_m1, r_sq, r_y, r_m2;
  logic [3:0] xa2, xb2;
  logic [3:0] m1_aa_q, m1_ab_q, m1_ba_q, m1_bb_q;
  logic [3:0] sqa_q, sqb_q;
  logic [3:0] ya, yb, y4a, y4b;
  logic [3:0] m2_aa_q, m2_ab_q, m2_ba_q, m2_bb_q;
  logic [3:0] za, zb;

  assign r_m1 = {rand_i[RAND_Z0 +: 2], rand_i[RAND_Z1 +: 2]};
  assign r_sq = {rand_i[RAND_AZ0 +: 2], rand_i[RAND_AZ1 +: 2]};
  assign r_y  = {rand_i[RAND_BZ0 +: 2], rand_i[RAND_BZ1 +: 2]};
  assign r_m2 = {rand_i[RAND_Z2 +: 2], rand_i[RAND_AZ2 +: 2] ^ rand_i[RAND_BZ2 +: 2]};

  assign xa2 = gf_sq(a_i);
  assign xb2 = gf_sq(b_i);

  // Cross-domain terms stay in separate registers until after the flop so
  // shares are never combined before the fresh mask is applied.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m1_aa_q <= '0; m1_ab_q <= '0; m1_ba_q <= '0; m1_bb_q <= '0;
      sqa_q   <= '0; sqb_q   <= '0;
      m2_aa_q <= '0; m2_ab_q <= '0; m2_ba_q <= '0; m2_bb_q <= '0;
    end else begin
      m1_aa_q <= gf_mul(a_i, xa2);
      m1_ab_q <= gf_mul(a_i, xb2) ^ r_m1;
      m1_ba_q <= gf_mul(b_i, xa2) ^ r_m1;
      m1_bb_q <= gf_mul(b_i, xb2);
      sqa_q   <= xa2 ^ r_sq;
      sqb_q   <= xb2 ^ r_sq;
      m2_aa_q <= gf_mul(y4a, sqa_q);
      m2_ab_q <= gf_mul(y4a, sqb_q) ^ r_m2;
      m2_ba_q <= gf_mul(y4b, sqa_q) ^ r_m2;
      m2_bb_q <= gf_mul(y4b, sqb_q);
    end
  end

  assign ya  = m1_aa_q ^ m1_ab_q;
  assign yb  = m1_bb_q ^ m1_ba_q;
  assign y4a = gf_sq(gf_sq(ya)) ^ r_y;
  assign y4b = gf_sq(gf_sq(yb)) ^ r_y;

  assign za  = m2_aa_q ^ m2_ab_q;
  assign zb  = m2_bb_q ^ m2_ba_q;
  assign a_o = saes_lin(za) ^ 4'h9;
  assign b_o = saes_lin(zb);

endmodule

// File: rtl/masked_subnib_seq.sv
// Sequencer feeding the masked S-box one nibble per cycle, collecting the
// shares and presenting masked SubNibbles (optionally + ShiftRows) results.
module masked_subnib_seq
  import masked_subnib_seq_pkg::*;
#(
  parameter bit SHIFT_ROWS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_a,
  input  logic [STATE_W-1:0] state_b,
  input  logic [RAND_W-1:0]  rand_in,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] out_a,
  output logic [STATE_W-1:0] out_b
);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] sa_q, sb_q;
  logic [STATE_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [STATE_W-1:0] outa_q, outb_q, fin_a, fin_b;
  logic               done_q;
  logic               load, issue, capture, finish;
  logic [1:0]         iss_idx, cap_idx;
  logic [NIB_W-1:0]   sbox_ai, sbox_bi, sbox_ao, sbox_bo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (cnt_q == 3'(LAST_CNT)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    load    = (state_q == IDLE) && start;
    issue   = busy && (cnt_q < 3'(NUM_NIB));
    capture = busy && (cnt_q >= 3'(SBOX_LAT));
    finish  = busy && (cnt_q == 3'(LAST_CNT));
    iss_idx = cnt_q[1:0];
    cap_idx = 2'(cnt_q - 3'(SBOX_LAT));
  end

  assign sbox_ai = issue ? sa_q[nib_lo(iss_idx) +: NIB_W] : '0;
  assign sbox_bi = issue ? sb_q[nib_lo(iss_idx) +: NIB_W] : '0;

  masked_subnib_seq_sbox u_sbox (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (sbox_ai),
    .b_i    (sbox_bi),
    .rand_i (rand_in),
    .a_o    (sbox_ao),
    .b_o    (sbox_bo)
  );

  // At cnt=LAST_CNT the capture writes n3, so ra_d/rb_d already hold the
  // complete result with n3 straight from the S-box outputs.
  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    if (capture) begin
      ra_d[nib_lo(cap_idx) +: NIB_W] = sbox_ao;
      rb_d[nib_lo(cap_idx) +: NIB_W] = sbox_bo;
    end
  end

  assign fin_a = SHIFT_ROWS ? {ra_d[15:12], ra_d[3:0], ra_d[7:4], ra_d[11:8]} : ra_d;
  assign fin_b = SHIFT_ROWS ? {rb_d[15:12], rb_d[3:0], rb_d[7:4], rb_d[11:8]} : rb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      outa_q <= '0;
      outb_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        sa_q <= state_a;
        sb_q <= state_b;
      end
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      done_q <= finish;
      if (finish) begin
        outa_q <= fin_a;
        outb_q <= fin_b;
      end
    end
  end

  assign done  = done_q;
  assign out_a = outa_q;
  assign out_b = outb_q;

endmodule

// File: tb/tb_masked_subnib_seq.sv
// Directed bench for masked_subnib_seq: two instances (SubNibbles only and
// with ShiftRows) driven by the same stimulus, results unmasked by the bench.
module tb_masked_subnib_seq;

  logic        clk, rst, start;
  logic [15:0] state_a, state_b;
  logic [17:0] rand_in;
  logic        busy0, done0, busy1, done1;
  logic [15:0] out_a0, out_b0, out_a1, out_b1;
  logic        rand_zero;

  int n_total, n_pass;
  int lat, bcnt, seen;
  logic [15:0] x0, x1, v, hold_a0, hold_b0, hold_a1, hold_b1;

  masked_subnib_seq #(.SHIFT_ROWS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .state_a(state_a), .state_b(state_b),
    .rand_in(rand_in), .busy(busy0), .done(done0), .out_a(out_a0), .out_b(out_b0));

  masked_subnib_seq #(.SHIFT_ROWS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .state_a(state_a), .state_b(state_b),
    .rand_in(rand_in), .busy(busy1), .done(done1), .out_a(out_a1), .out_b(out_b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rand_in = '0;
    forever begin
      @(posedge clk);
      #2;
      rand_in = rand_zero ? 18'h0 : 18'($urandom);
    end
  end

  function automatic logic [3:0] sb(input logic [3:0] n);
    case (n)
      4'h0: return 4'h9; 4'h1: return 4'h4; 4'h2: return 4'hA; 4'h3: return 4'hB;
      4'h4: return 4'hD; 4'h5: return 4'h1; 4'h6: return 4'h8; 4'h7: return 4'h5;
      4'h8: return 4'h6; 4'h9: return 4'h2; 4'hA: return 4'h0; 4'hB: return 4'h3;
      4'hC: return 4'hC; 4'hD: return 4'hE; 4'hE: return 4'hF; default: return 4'h7;
    endcase
  endfunction

  function automatic logic [15:0] subnib(input logic [15:0] s);
    return {sb(s[15:12]), sb(s[11:8]), sb(s[7:4]), sb(s[3:0])};
  endfunction

  function automatic logic [15:0] shrows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts one operation on a freshly masked v; state inputs are scrambled
  // while the operation runs.  Returns unmasked results and latency.
  task automatic run_op(input logic [15:0] val, input logic zero_mask,
                        output logic [15:0] r0, output logic [15:0] r1,
                        output int l, output int b);
    logic [15:0] m;
    m = zero_mask ? 16'h0 : 16'($urandom);
    state_a = val ^ m;
    state_b = m;
    start = 1'b1;
    step();
    start = 1'b0;
    l = 0;
    b = 0;
    while (!done0 && l < 20) begin
      if (busy0) b++;
      state_a = 16'($urandom);
      state_b = 16'($urandom);
      step();
      l++;
    end
    r0 = out_a0 ^ out_b0;
    r1 = out_a1 ^ out_b1;
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    rand_zero = 1'b1;
    rst = 1'b1;
    start = 1'b0;
    state_a = '0;
    state_b = '0;
    step();
    step();
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_done", {31'd0, done0}, 32'd0);
    chk("reset_out", {out_a0, out_b0}, 32'h0);
    rst = 1'b0;
    step();

    // all-zero state with zero randomness
    run_op(16'h0000, 1'b1, x0, x1, lat, bcnt);
    chk("zero_lat", lat, 6);
    chk("zero_busy", bcnt, 6);
    chk("zero_res0", {16'h0, x0}, {16'h0, 16'h9999});
    chk("zero_res1", {16'h0, x1}, {16'h0, 16'h9999});
    chk("zero_done1", {31'd0, done1}, 32'd1);
    step();
    chk("done_pulse", {30'd0, done0, done1}, 32'd0);

    rand_zero = 1'b0;
    run_op(16'h1234, 1'b0, x0, x1, lat, bcnt);
    chk("h1234_sn", {16'h0, x0}, {16'h0, 16'h4ABD});
    chk("h1234_sr", {16'h0, x1}, {16'h0, 16'h4DBA});
    chk("h1234_lat", lat, 6);

    // S-box sweep, same value in all four nibbles, several mask sets each
    for (int unsigned k = 0; k < 16; k++) begin
      v = {4{4'(k)}};
      for (int unsigned j = 0; j < 3; j++) begin
        run_op(v, 1'b0, x0, x1, lat, bcnt);
        chk($sformatf("sweep%0h_sn", k), {16'h0, x0}, {16'h0, {4{sb(4'(k))}}});
        chk($sformatf("sweep%0h_sr", k), {16'h0, x1}, {16'h0, {4{sb(4'(k))}}});
      end
    end

    // mixed-value vectors
    run_op(16'hF00D, 1'b0, x0, x1, lat, bcnt);
    chk("hF00D_sn", {16'h0, x0}, {16'h0, 16'h799E});
    chk("hF00D_sr", {16'h0, x1}, {16'h0, 16'h7E99});
    run_op(16'h5A6C, 1'b0, x0, x1, lat, bcnt);
    chk("h5A6C_sn", {16'h0, x0}, {16'h0, subnib(16'h5A6C)});
    chk("h5A6C_sr", {16'h0, x1}, {16'h0, shrows(subnib(16'h5A6C))});

    // start held high: accepted only in IDLE / done cycles
    v = 16'($urandom);
    state_a = 16'hC3A7 ^ v;
    state_b = v;
    start = 1'b1;
    step();
    lat = 0;
    while (!done0 && lat < 20) begin
      state_a = 16'($urandom);
      state_b = 16'($urandom);
      step();
      lat++;
    end
    chk("held_lat1", lat, 6);
    chk("held_res1", {16'h0, out_a0 ^ out_b0}, {16'h0, subnib(16'hC3A7)});
    v = 16'($urandom);
    state_a = 16'h0F81 ^ v;
    state_b = v;
    step();
    lat = 1;
    while (!done0 && lat < 20) begin
      state_a = 16'($urandom);
      state_b = 16'($urandom);
      step();
      lat++;
    end
    start = 1'b0;
    chk("held_interval", lat, 7);
    chk("held_res2_sn", {16'h0, out_a0 ^ out_b0}, {16'h0, subnib(16'h0F81)});
    chk("held_res2_sr", {16'h0, out_a1 ^ out_b1}, {16'h0, shrows(subnib(16'h0F81))});
    step();

    // reset during cnt=3
    state_a = 16'h1111;
    state_b = 16'h2222;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_out0", {out_a0, out_b0}, 32'h0);
    chk("abort_out1", {out_a1, out_b1}, 32'h0);
    seen = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      step();
      if (done0 || done1) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(16'h9E27, 1'b0, x0, x1, lat, bcnt);
    chk("after_abort_lat", lat, 6);
    chk("after_abort_sn", {16'h0, x0}, {16'h0, subnib(16'h9E27)});
    chk("after_abort_sr", {16'h0, x1}, {16'h0, shrows(subnib(16'h9E27))});

    // output hold with start low
    hold_a0 = out_a0; hold_b0 = out_b0; hold_a1 = out_a1; hold_b1 = out_b1;
    seen = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      state_a = 16'($urandom);
      state_b = 16'($urandom);
      step();
      if (done0 || done1 || busy0) seen++;
    end
    chk("hold_ctrl", seen, 0);
    chk("hold_out0", {out_a0, out_b0}, {hold_a0, hold_b0});
    chk("hold_out1", {out_a1, out_b1}, {hold_a1, hold_b1});
    chk("hold_val", {16'h0, out_a0 ^ out_b0}, {16'h0, subnib(16'h9E27)});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
